// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size codes, FSM states and default base address for the data memory responder
package dmem_pkg;
  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;
  localparam logic [31:0] BASE_ADDR_DEF = 32'h0001_0000;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: load extraction/extension, store byte merging and size/alignment legality
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [2:0]  size,
  input  logic [1:0]  lane,
  input  logic        we,
  output logic [31:0] rdata,
  output logic [31:0] merged,
  output logic        bad
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [3:0]  be;
  logic [31:0] rep;
  logic [31:0] m;
  // lane selection, extension, byte-enable merge and illegal-access detection
  always_comb begin
    b      = word[{lane, 3'b000} +: 8];
    h      = lane[1] ? word[31:16] : word[15:0];
    rdata  = size == LS_B  ? {{24{b[7]}}, b} :
             size == LS_BU ? {24'h0, b} :
             size == LS_H  ? {{16{h[15]}}, h} :
             size == LS_HU ? {16'h0, h} :
             size == LS_W  ? word : '0;
    be     = size[1:0] == 2'b00 ? 4'b0001 << lane :
             size[1:0] == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    rep    = size[1:0] == 2'b00 ? {4{wdata[7:0]}} :
             size[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
    m      = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    merged = (word & ~m) | (rep & m);
    bad    = size == 3'b011 || size[2:1] == 2'b11 || (size[1:0] == 2'b01 && lane[0]) ||
             (size == LS_W && lane != 2'b00) || (we && size[2]);
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency RV32I load/store data memory with valid/ready request and response
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF,
  parameter int          LATENCY     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_size,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);
  localparam int IW = $clog2(DEPTH_WORDS);
  state_t           state, nxt;
  logic [3:0]       cnt;
  logic             we_q;
  logic [2:0]       size_q;
  logic [WIDTH-1:0] addr_q, wdata_q, off;
  logic [31:0]      mem [DEPTH_WORDS];
  logic [IW-1:0]    idx;
  logic [31:0]      ld, merged;
  logic             bad, err, done, accept;
  dmem_lane_align u_align (
    .word   (mem[idx]),
    .wdata  (wdata_q),
    .size   (size_q),
    .lane   (off[1:0]),
    .we     (we_q),
    .rdata  (ld),
    .merged (merged),
    .bad    (bad)
  );
  // decode of the latched request and next-state selection
  always_comb begin
    off       = addr_q - BASE_ADDR;
    idx       = off[IW+1:2];
    err       = bad || off >= WIDTH'(DEPTH_WORDS * 4);
    req_ready = state == IDLE && !rst;
    accept    = req_valid && req_ready;
    done      = state == WAIT && cnt == 4'd0;
    nxt       = state == IDLE ? (accept ? WAIT : IDLE) :
                state == WAIT ? (done ? RESP : WAIT) :
                (rsp_ready ? IDLE : RESP);
  end
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  // latency counter and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) cnt <= 4'(LATENCY - 1);
      else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (done) begin
        rsp_valid <= 1'b1;
        rsp_err   <= err;
        rsp_rdata <= (err || we_q) ? '0 : WIDTH'(ld);
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end
  // request capture; contents are don't-care until the next accept
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end
  // storage write on the commit edge of a legal store; never cleared by reset
  always_ff @(posedge clk) begin
    if (!rst && done && we_q && !err) mem[idx] <= merged;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks against a byte-addressed reference model
module tb_dmem_responder;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int LAT = 2;
  logic        clk = 0, rst = 1;
  logic        req_valid = 0, req_ready, req_we = 0;
  logic [2:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        rsp_valid, rsp_ready = 1, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  bm [4096];
  int checks = 0, failures = 0;
  logic [31:0] rd, xrd;
  logic        e, xe;

  dmem_responder #(.WIDTH(32), .DEPTH_WORDS(1024), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic mdl(input logic we, input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] r, output logic er);
    logic [31:0] off;
    int n;
    off = addr - BASE;
    n = sz[1:0] == 2'd0 ? 1 : sz[1:0] == 2'd1 ? 2 : 4;
    er = sz == 3'd3 || sz >= 3'd6 || (we && sz >= 3'd4) || off >= 32'd4096 || (off % n) != 0;
    r = 0;
    if (!er) begin
      if (we) for (int i = 0; i < n; i++) bm[off + i] = wd[8*i +: 8];
      else begin
        for (int i = 0; i < n; i++) r |= 32'(bm[off + i]) << (8 * i);
        if (sz < 3'd4 && n < 4 && r[8*n-1]) r |= 32'hFFFF_FFFF << (8 * n);
      end
    end
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, LAT);
  endtask

  task automatic xact(input logic we, input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] r, output logic er);
    check("req_ready_idle", 32'(req_ready), 1);
    req_valid = 1; req_we = we; req_size = sz; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 0;
    wait_rsp("xact");
    r = rsp_rdata; er = rsp_err;
    mdl(we, sz, addr, wd, xrd, xe);
    check("rdata", r, xrd);
    check("err", 32'(er), 32'(xe));
    @(posedge clk); #1;
    check("rsp_drop", 32'(rsp_valid), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", 32'(rsp_err), 0);
    check("rst_ready", 32'(req_ready), 0);
    rst = 0; #1;
    for (int w = 0; w < 16; w++) xact(1, 3'b010, BASE + 32'(4 * w), $urandom, rd, e);
    xact(1, 3'b010, BASE, 32'hDEADBEEF, rd, e);
    xact(0, 3'b010, BASE, 0, rd, e);     check("lw", rd, 32'hDEADBEEF);
    xact(0, 3'b000, BASE + 3, 0, rd, e); check("lb", rd, 32'hFFFFFFDE);
    xact(0, 3'b100, BASE + 3, 0, rd, e); check("lbu", rd, 32'h000000DE);
    xact(0, 3'b001, BASE + 2, 0, rd, e); check("lh", rd, 32'hFFFFDEAD);
    xact(0, 3'b101, BASE + 2, 0, rd, e); check("lhu", rd, 32'h0000DEAD);
    xact(1, 3'b000, BASE + 1, 32'h12, rd, e);
    xact(0, 3'b010, BASE, 0, rd, e);     check("sb_lw", rd, 32'hDEAD12EF);
    xact(1, 3'b001, BASE + 2, 32'hCAFE, rd, e);
    xact(0, 3'b010, BASE, 0, rd, e);     check("sh_lw", rd, 32'hCAFE12EF);
    xact(1, 3'b010, BASE + 4, 32'h0BADF00D, rd, e);
    xact(0, 3'b010, BASE + 2, 0, rd, e); check("e_lw_mis", 32'(e), 1);
    xact(1, 3'b001, BASE + 1, 32'hFFFF, rd, e); check("e_sh_mis", 32'(e), 1);
    xact(0, 3'b010, 32'h0, 0, rd, e);    check("e_oor", 32'(e), 1);
    xact(0, 3'b011, BASE, 0, rd, e);     check("e_size", 32'(e), 1);
    check("e_rdata", rd, 0);
    xact(1, 3'b010, BASE + 6, 32'h0, rd, e); check("e_sw_mis", 32'(e), 1);
    xact(0, 3'b010, BASE, 0, rd, e);     check("e_keep0", rd, 32'hCAFE12EF);
    xact(0, 3'b010, BASE + 4, 0, rd, e); check("e_keep4", rd, 32'h0BADF00D);
    // backpressure with a competing request held high
    rsp_ready = 0;
    req_valid = 1; req_we = 0; req_size = 3'b010; req_addr = BASE;
    @(posedge clk); #1;
    req_addr = BASE + 4; req_we = 1; req_wdata = 32'h55555555;
    wait_rsp("bp");
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(rsp_valid), 1);
      check("bp_rdata", rsp_rdata, 32'hCAFE12EF);
      check("bp_err", 32'(rsp_err), 0);
      check("bp_ready", 32'(req_ready), 0);
      @(posedge clk); #1;
    end
    req_valid = 0; rsp_ready = 1;
    @(posedge clk); #1;
    check("bp_drop", 32'(rsp_valid), 0);
    check("bp_idle", 32'(req_ready), 1);
    repeat (4) @(posedge clk);
    #1;
    check("bp_noacc", 32'(rsp_valid), 0);
    xact(0, 3'b010, BASE + 4, 0, rd, e); check("bp_nowrite", rd, 32'h0BADF00D);
    // reset during WAIT drops an uncommitted store
    xact(1, 3'b010, BASE + 4, 32'h11111111, rd, e);
    req_valid = 1; req_we = 1; req_size = 3'b010; req_addr = BASE + 4; req_wdata = 32'h22222222;
    @(posedge clk); #1;
    req_valid = 0; rst = 1; #1;
    check("rst_mid_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    rst = 0;
    for (int k = 0; k < 5; k++) begin
      check("rst_mid_norsp", 32'(rsp_valid), 0);
      @(posedge clk); #1;
    end
    xact(0, 3'b010, BASE + 4, 0, rd, e); check("rst_mid_mem", rd, 32'h11111111);
    // request presented together with reset is not accepted
    rst = 1; req_valid = 1; req_we = 1; req_size = 3'b010; req_addr = BASE + 4; req_wdata = 32'h33333333;
    @(posedge clk); #1;
    rst = 0; req_valid = 0;
    repeat (4) begin
      check("rst_req_norsp", 32'(rsp_valid), 0);
      @(posedge clk); #1;
    end
    xact(0, 3'b010, BASE + 4, 0, rd, e); check("rst_req_mem", rd, 32'h11111111);
    // random traffic
    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      int r = $urandom_range(0, 9);
      int r2 = $urandom_range(0, 2);
      a = r != 0 ? BASE + 32'($urandom_range(0, 63)) :
          r2 == 0 ? BASE - 4 : r2 == 1 ? BASE + 32'd4096 : 32'h0;
      xact(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, rd, e);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
